// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
//   Operand forwarding selects plus hazard detection for the 5-stage RISC-V
//   pipeline. It combines a load-use check with a countdown scoreboard for a
//   single non-pipelined long-latency unit (MUL/DIV). It drives the PC/IF_ID
//   hold and the ID_EX bubble through stall_o.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   IF_ID_RS_i          source registers of the instruction in ID (NUM_SRC x REG_AW)
//   IF_ID_RS_valid_i    per-source "operand used" mask for the ID instruction
//   IF_ID_LongOp_i      ID instruction needs the long-latency unit
//   ID_EX_RS_i          source registers of the instruction in EX
//   ID_EX_MemRead_i     EX instruction is a load
//   ID_EX_RD_i          EX destination register
//   STG_RegWrite_i      per forwarding stage RegWrite (index 0 = nearest)
//   STG_RD_i            per forwarding stage destination register
//   LOP_Issue_i         long op enters the unit this cycle
//   LOP_RD_i            destination of the issuing long op
//   Forward_o           per-source select: 0 = regfile, k = stage k-1
//   stall_o             hold PC/IF_ID and bubble ID_EX
//   LOP_Busy_o          long unit occupied
//   LOP_WB_o            long-op writeback cycle pulse
//   LOP_WB_RD_o         register being written back by the long op (else 0)
//   StallCount_o        saturating count of stall cycles
//   Error_o             sticky protocol error (issue into a busy unit)
module fwd_hazard_scoreboard #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_AW         = 5,
  parameter int LOP_LAT        = 4,
  parameter int CNT_W          = 16,
  localparam int FSEL_W        = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_SRC*REG_AW-1:0]    IF_ID_RS_i,
  input  logic [NUM_SRC-1:0]           IF_ID_RS_valid_i,
  input  logic                         IF_ID_LongOp_i,
  input  logic [NUM_SRC*REG_AW-1:0]    ID_EX_RS_i,
  input  logic                         ID_EX_MemRead_i,
  input  logic [REG_AW-1:0]            ID_EX_RD_i,
  input  logic [NUM_FWD_STAGES-1:0]    STG_RegWrite_i,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] STG_RD_i,
  input  logic                         LOP_Issue_i,
  input  logic [REG_AW-1:0]            LOP_RD_i,
  output logic [NUM_SRC*FSEL_W-1:0]    Forward_o,
  output logic                         stall_o,
  output logic                         LOP_Busy_o,
  output logic                         LOP_WB_o,
  output logic [REG_AW-1:0]            LOP_WB_RD_o,
  output logic [CNT_W-1:0]             StallCount_o,
  output logic                         Error_o
);

  localparam int BC_W = $clog2(LOP_LAT + 1);
  localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAT = BC_W'(LOP_LAT);

  logic [BC_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic [REG_AW-1:0] busy_rd_q,  busy_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              error_q,    error_d;

  logic busy_gt1;
  logic issue_ok;
  logic load_use;
  logic lop_raw;
  logic structural;

  // Forwarding: walk from the farthest stage inward so the nearest match
  // is the last assignment and therefore wins.
  always_comb begin
    Forward_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        if (STG_RegWrite_i[k] &&
            (STG_RD_i[k*REG_AW +: REG_AW] != '0) &&
            (STG_RD_i[k*REG_AW +: REG_AW] == ID_EX_RS_i[s*REG_AW +: REG_AW])) begin
          Forward_o[s*FSEL_W +: FSEL_W] = FSEL_W'(k + 1);
        end
      end
    end
  end

  // At busy_cnt==1 the result is written this cycle and the regfile is
  // write-through, so only counts above 1 block consumers or a new issue.
  assign busy_gt1 = (busy_cnt_q > BC_ONE);
  assign issue_ok = LOP_Issue_i && !busy_gt1;

  always_comb begin
    load_use = 1'b0;
    lop_raw  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (IF_ID_RS_valid_i[s]) begin
        if (ID_EX_MemRead_i && (ID_EX_RD_i != '0) &&
            (IF_ID_RS_i[s*REG_AW +: REG_AW] == ID_EX_RD_i)) begin
          load_use = 1'b1;
        end
        // x0 never carries a dependency, even when it is a long-op target.
        if (IF_ID_RS_i[s*REG_AW +: REG_AW] != '0) begin
          if (busy_gt1 && (IF_ID_RS_i[s*REG_AW +: REG_AW] == busy_rd_q)) begin
            lop_raw = 1'b1;
          end
          if (LOP_Issue_i && (IF_ID_RS_i[s*REG_AW +: REG_AW] == LOP_RD_i)) begin
            lop_raw = 1'b1;
          end
        end
      end
    end
  end

  assign structural = IF_ID_LongOp_i && (busy_gt1 || LOP_Issue_i);
  assign stall_o    = load_use || lop_raw || structural;

  // Scoreboard next state. An issue into a unit with more than one cycle
  // left is dropped; the running op keeps counting and the error sticks.
  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    busy_rd_d   = busy_rd_q;
    stall_cnt_d = stall_cnt_q;
    error_d     = error_q;
    if (issue_ok) begin
      busy_cnt_d = BC_LAT;
      busy_rd_d  = LOP_RD_i;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - BC_ONE;
    end
    if (LOP_Issue_i && busy_gt1) begin
      error_d = 1'b1;
    end
    if (stall_o && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_cnt_q  <= '0;
      busy_rd_q   <= '0;
      stall_cnt_q <= '0;
      error_q     <= 1'b0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      busy_rd_q   <= busy_rd_d;
      stall_cnt_q <= stall_cnt_d;
      error_q     <= error_d;
    end
  end

  assign LOP_Busy_o   = (busy_cnt_q != '0);
  assign LOP_WB_o     = (busy_cnt_q == BC_ONE);
  assign LOP_WB_RD_o  = LOP_WB_o ? busy_rd_q : '0;
  assign StallCount_o = stall_cnt_q;
  assign Error_o      = error_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed testbench for fwd_hazard_scoreboard (NUM_SRC=2, NUM_FWD_STAGES=2,
// REG_AW=5, LOP_LAT=4, CNT_W=4 so counter saturation is reachable quickly).
module tb_fwd_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [9:0]  if_id_rs;
  logic [1:0]  if_id_rs_valid;
  logic        if_id_longop;
  logic [9:0]  id_ex_rs;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic [1:0]  stg_regwrite;
  logic [9:0]  stg_rd;
  logic        lop_issue;
  logic [4:0]  lop_rd;
  logic [3:0]  forward;
  logic        stall;
  logic        lop_busy;
  logic        lop_wb;
  logic [4:0]  lop_wb_rd;
  logic [3:0]  stall_count;
  logic        error;

  int total;
  int passed;

  fwd_hazard_scoreboard #(
    .NUM_SRC(2), .NUM_FWD_STAGES(2), .REG_AW(5), .LOP_LAT(4), .CNT_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .IF_ID_RS_i(if_id_rs), .IF_ID_RS_valid_i(if_id_rs_valid),
    .IF_ID_LongOp_i(if_id_longop),
    .ID_EX_RS_i(id_ex_rs), .ID_EX_MemRead_i(id_ex_memread), .ID_EX_RD_i(id_ex_rd),
    .STG_RegWrite_i(stg_regwrite), .STG_RD_i(stg_rd),
    .LOP_Issue_i(lop_issue), .LOP_RD_i(lop_rd),
    .Forward_o(forward), .stall_o(stall), .LOP_Busy_o(lop_busy),
    .LOP_WB_o(lop_wb), .LOP_WB_RD_o(lop_wb_rd),
    .StallCount_o(stall_count), .Error_o(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    if_id_rs = '0; if_id_rs_valid = '0; if_id_longop = 1'b0;
    id_ex_rs = '0; id_ex_memread = 1'b0; id_ex_rd = '0;
    stg_regwrite = '0; stg_rd = '0; lop_issue = 1'b0; lop_rd = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    settle();
    total++; if (lop_busy !== 1'b0) $display("FAIL rst_busy got=%0d exp=0", lop_busy); else passed++;
    total++; if (stall_count !== 4'd0) $display("FAIL rst_stallcnt got=%0d exp=0", stall_count); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rst_error got=%0d exp=0", error); else passed++;
    total++; if (lop_wb !== 1'b0) $display("FAIL rst_wb got=%0d exp=0", lop_wb); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rst_stall got=%0d exp=0", stall); else passed++;
    total++; if (forward !== 4'd0) $display("FAIL rst_fwd got=%0d exp=0", forward); else passed++;
  endtask

  task automatic test_forwarding;
    do_reset();
    stg_regwrite = 2'b11; stg_rd = {5'd5, 5'd5}; id_ex_rs = {5'd5, 5'd5};
    settle();
    total++; if (forward !== 4'b0101) $display("FAIL fwd_both got=%b exp=0101", forward); else passed++;
    step();
    stg_regwrite = 2'b10;
    settle();
    total++; if (forward !== 4'b1010) $display("FAIL fwd_stage1 got=%b exp=1010", forward); else passed++;
    step();
    stg_regwrite = 2'b11; stg_rd = {5'd0, 5'd0}; id_ex_rs = {5'd0, 5'd0};
    settle();
    total++; if (forward !== 4'b0000) $display("FAIL fwd_x0 got=%b exp=0000", forward); else passed++;
    step();
    // src0 = x5 found in stage 1, src1 = x6 found in stage 0
    stg_rd = {5'd5, 5'd6}; id_ex_rs = {5'd6, 5'd5};
    settle();
    total++; if (forward !== 4'b0110) $display("FAIL fwd_mixed got=%b exp=0110", forward); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL fwd_nostall got=%0d exp=0", stall); else passed++;
  endtask

  task automatic test_load_use;
    do_reset();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; if_id_rs = {5'd0, 5'd7}; if_id_rs_valid = 2'b01;
    settle();
    total++; if (stall !== 1'b1) $display("FAIL lu_stall got=%0d exp=1", stall); else passed++;
    step();
    id_ex_memread = 1'b0; id_ex_rd = 5'd0;   // bubble now in EX
    settle();
    total++; if (stall !== 1'b0) $display("FAIL lu_release got=%0d exp=0", stall); else passed++;
    total++; if (stall_count !== 4'd1) $display("FAIL lu_count got=%0d exp=1", stall_count); else passed++;
    step();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; if_id_rs_valid = 2'b10;
    settle();
    total++; if (stall !== 1'b0) $display("FAIL lu_invalid got=%0d exp=0", stall); else passed++;
    step();
    if_id_rs = {5'd7, 5'd0};
    settle();
    total++; if (stall !== 1'b1) $display("FAIL lu_src1 got=%0d exp=1", stall); else passed++;
    step();
    idle_inputs();
    settle();
    total++; if (stall_count !== 4'd2) $display("FAIL lu_count2 got=%0d exp=2", stall_count); else passed++;
  endtask

  task automatic test_long_op;
    do_reset();
    lop_issue = 1'b1; lop_rd = 5'd9; if_id_rs = {5'd0, 5'd9}; if_id_rs_valid = 2'b01;
    settle();
    total++; if (stall !== 1'b1) $display("FAIL lop_issue_stall got=%0d exp=1", stall); else passed++;
    step();
    lop_issue = 1'b0; lop_rd = 5'd0;
    for (int c = 4; c >= 2; c--) begin
      settle();
      total++; if (stall !== 1'b1) $display("FAIL lop_raw_cnt%0d got=%0d exp=1", c, stall); else passed++;
      total++; if (lop_busy !== 1'b1 || lop_wb !== 1'b0) $display("FAIL lop_busy_cnt%0d got=%0d%0d exp=10", c, lop_busy, lop_wb); else passed++;
      step();
    end
    settle();
    total++; if (stall !== 1'b0) $display("FAIL lop_wb_stall got=%0d exp=0", stall); else passed++;
    total++; if (lop_wb !== 1'b1) $display("FAIL lop_wb got=%0d exp=1", lop_wb); else passed++;
    total++; if (lop_wb_rd !== 5'd9) $display("FAIL lop_wb_rd got=%0d exp=9", lop_wb_rd); else passed++;
    total++; if (stall_count !== 4'd4) $display("FAIL lop_count got=%0d exp=4", stall_count); else passed++;
    step();
    settle();
    total++; if (lop_busy !== 1'b0 || lop_wb !== 1'b0) $display("FAIL lop_done got=%0d%0d exp=00", lop_busy, lop_wb); else passed++;
    total++; if (lop_wb_rd !== 5'd0) $display("FAIL lop_done_rd got=%0d exp=0", lop_wb_rd); else passed++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    lop_issue = 1'b1; lop_rd = 5'd3; if_id_longop = 1'b1;
    settle();
    total++; if (stall !== 1'b1) $display("FAIL b2b_issue_stall got=%0d exp=1", stall); else passed++;
    step();
    lop_issue = 1'b0; lop_rd = 5'd0;
    for (int c = 4; c >= 2; c--) begin
      settle();
      total++; if (stall !== 1'b1) $display("FAIL b2b_struct_cnt%0d got=%0d exp=1", c, stall); else passed++;
      step();
    end
    // count is 1: the waiting long op advances and issues now
    if_id_longop = 1'b0; lop_issue = 1'b1; lop_rd = 5'd4;
    settle();
    total++; if (stall !== 1'b0) $display("FAIL b2b_cnt1_stall got=%0d exp=0", stall); else passed++;
    total++; if (lop_wb !== 1'b1 || lop_wb_rd !== 5'd3) $display("FAIL b2b_wb1 got=%0d/%0d exp=1/3", lop_wb, lop_wb_rd); else passed++;
    step();
    lop_issue = 1'b0; lop_rd = 5'd0;
    for (int c = 4; c >= 2; c--) begin
      settle();
      total++; if (lop_busy !== 1'b1 || lop_wb !== 1'b0) $display("FAIL b2b_reload_cnt%0d got=%0d%0d exp=10", c, lop_busy, lop_wb); else passed++;
      step();
    end
    settle();
    total++; if (lop_wb !== 1'b1 || lop_wb_rd !== 5'd4) $display("FAIL b2b_wb2 got=%0d/%0d exp=1/4", lop_wb, lop_wb_rd); else passed++;
    total++; if (error !== 1'b0) $display("FAIL b2b_error got=%0d exp=0", error); else passed++;
    total++; if (stall_count !== 4'd4) $display("FAIL b2b_count got=%0d exp=4", stall_count); else passed++;
    step();
  endtask

  task automatic test_protocol_error;
    do_reset();
    lop_issue = 1'b1; lop_rd = 5'd9;
    step();
    lop_issue = 1'b0;
    step();
    // count is 3: illegal issue
    lop_issue = 1'b1; lop_rd = 5'd12;
    step();
    lop_issue = 1'b0; lop_rd = 5'd0;
    settle();
    total++; if (error !== 1'b1) $display("FAIL perr_set got=%0d exp=1", error); else passed++;
    total++; if (lop_busy !== 1'b1 || lop_wb !== 1'b0) $display("FAIL perr_cnt2 got=%0d%0d exp=10", lop_busy, lop_wb); else passed++;
    step();
    settle();
    total++; if (lop_wb !== 1'b1 || lop_wb_rd !== 5'd9) $display("FAIL perr_wb got=%0d/%0d exp=1/9", lop_wb, lop_wb_rd); else passed++;
    step();
    step();
    settle();
    total++; if (lop_busy !== 1'b0) $display("FAIL perr_idle got=%0d exp=0", lop_busy); else passed++;
    total++; if (error !== 1'b1) $display("FAIL perr_sticky got=%0d exp=1", error); else passed++;
    do_reset();
    settle();
    total++; if (error !== 1'b0) $display("FAIL perr_clear got=%0d exp=0", error); else passed++;
  endtask

  task automatic test_reset_mid_op;
    do_reset();
    lop_issue = 1'b1; lop_rd = 5'd9; if_id_rs = {5'd0, 5'd9}; if_id_rs_valid = 2'b01;
    step();
    lop_issue = 1'b0; lop_rd = 5'd0;
    step();
    step();
    settle();
    total++; if (stall_count !== 4'd3) $display("FAIL rmid_pre_count got=%0d exp=3", stall_count); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    total++; if (lop_busy !== 1'b0) $display("FAIL rmid_busy got=%0d exp=0", lop_busy); else passed++;
    total++; if (lop_wb !== 1'b0) $display("FAIL rmid_wb got=%0d exp=0", lop_wb); else passed++;
    total++; if (stall_count !== 4'd0) $display("FAIL rmid_count got=%0d exp=0", stall_count); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rmid_stall got=%0d exp=0", stall); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rmid_error got=%0d exp=0", error); else passed++;
  endtask

  task automatic test_x0_long_op;
    do_reset();
    lop_issue = 1'b1; lop_rd = 5'd0; if_id_rs = {5'd0, 5'd0}; if_id_rs_valid = 2'b11;
    settle();
    total++; if (stall !== 1'b0) $display("FAIL x0_issue got=%0d exp=0", stall); else passed++;
    step();
    lop_issue = 1'b0;
    settle();
    total++; if (stall !== 1'b0 || lop_busy !== 1'b1) $display("FAIL x0_busy got=%0d%0d exp=01", stall, lop_busy); else passed++;
    step();
    if_id_longop = 1'b1;
    settle();
    total++; if (stall !== 1'b1) $display("FAIL x0_struct got=%0d exp=1", stall); else passed++;
    step();
    idle_inputs();
  endtask

  task automatic test_saturation;
    do_reset();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; if_id_rs = {5'd0, 5'd7}; if_id_rs_valid = 2'b01;
    for (int i = 0; i < 14; i++) step();
    settle();
    total++; if (stall_count !== 4'd14) $display("FAIL sat_14 got=%0d exp=14", stall_count); else passed++;
    for (int i = 0; i < 6; i++) step();
    settle();
    total++; if (stall_count !== 4'd15) $display("FAIL sat_20 got=%0d exp=15", stall_count); else passed++;
    step();
    idle_inputs();
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_long_op();
    test_back_to_back();
    test_protocol_error();
    test_reset_mid_op();
    test_x0_long_op();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
